// File: rtl/song_recorder.sv
// rtl/song_recorder.sv - free-play recorder: debounced keys to 4-bit note/duration memory
// Optional live buzzer/LED monitor is built when REC_LIVE_MONITOR_EN is defined.
module song_recorder #(
  parameter int DEPTH           = 56,
  parameter int TICK_CYCLES     = 17500000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_DUR         = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] key_in,
  input  logic       rec_start,
  input  logic       rec_stop,
  input  logic [5:0] rd_addr,
  output logic [3:0] rd_note,
  output logic [3:0] rd_dur,
  output logic [5:0] rec_len,
  output logic       recording,
  output logic       full,
  output logic [3:0] note_to_play,
  output logic [6:0] led_out
);
  localparam int         TW        = $clog2(TICK_CYCLES + 1);
  localparam int         DW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [5:0] LAST      = 6'(DEPTH - 1);
  localparam logic [3:0] DUR_MAX   = 4'(MAX_DUR);
  localparam logic [7:0] TERM_WORD = 8'hF0;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SEG, S_STOP, S_FILL, S_DONE} state_t;

  logic [3:0]    raw_code;
  logic [3:0]    cand_code;
  logic [3:0]    acc_code;
  logic [DW-1:0] stable_cnt;

  always_comb begin
    raw_code = 4'd0;
    for (int i = 6; i >= 0; i--) begin
      if (key_in[i]) raw_code = 4'(i + 1);
    end
  end

  // stable_cnt counts consecutive cycles the raw code has matched cand_code
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand_code  <= 4'd0;
      acc_code   <= 4'd0;
      stable_cnt <= '0;
    end else if (raw_code != cand_code) begin
      cand_code  <= raw_code;
      stable_cnt <= DW'(1);
    end else if (stable_cnt != DW'(DEBOUNCE_CYCLES)) begin
      stable_cnt <= stable_cnt + DW'(1);
      if (stable_cnt == DW'(DEBOUNCE_CYCLES - 1)) acc_code <= cand_code;
    end
  end

  state_t        state;
  logic [5:0]    wr_ptr;
  logic [3:0]    seg_code;
  logic [3:0]    dur_cnt;
  logic [TW-1:0] tick_cnt;
  logic          wr_en;
  logic [5:0]    wr_addr;
  logic [7:0]    wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wr_ptr    <= 6'd0;
      seg_code  <= 4'd0;
      dur_cnt   <= 4'd0;
      tick_cnt  <= '0;
      recording <= 1'b0;
      full      <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= 6'd0;
      wr_data   <= 8'd0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (rec_start && !rec_stop) begin
            state     <= S_ARMED;
            wr_ptr    <= 6'd0;
            full      <= 1'b0;
            recording <= 1'b1;
          end
        end
        S_ARMED: begin
          if (rec_stop) begin
            wr_en     <= 1'b1;
            wr_addr   <= wr_ptr;
            wr_data   <= TERM_WORD;
            state     <= S_DONE;
            recording <= 1'b0;
          end else if (acc_code != 4'd0) begin
            state    <= S_SEG;
            seg_code <= acc_code;
            dur_cnt  <= 4'd1;
            tick_cnt <= '0;
          end
        end
        S_SEG: begin
          // a code change closes the segment even when a tick lands in the same cycle
          if (rec_stop || acc_code != seg_code) begin
            wr_en    <= 1'b1;
            wr_addr  <= wr_ptr;
            wr_data  <= {seg_code, dur_cnt};
            wr_ptr   <= wr_ptr + 6'd1;
            seg_code <= acc_code;
            dur_cnt  <= 4'd1;
            tick_cnt <= '0;
            if (rec_stop) begin
              state     <= S_STOP;
              recording <= 1'b0;
            end else if (wr_ptr == LAST - 6'd1) begin
              state     <= S_FILL;
              recording <= 1'b0;
            end
          end else if (tick_cnt == TW'(TICK_CYCLES - 1)) begin
            tick_cnt <= '0;
            if (dur_cnt != DUR_MAX) dur_cnt <= dur_cnt + 4'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        S_STOP, S_FILL: begin
          wr_en   <= 1'b1;
          wr_addr <= wr_ptr;
          wr_data <= TERM_WORD;
          full    <= (state == S_FILL);
          state   <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rec_len = wr_ptr;

  // Full 6-bit address space keeps indexing width-clean for any DEPTH; no reset so takes survive reset
  logic [7:0] mem [64];
  logic [7:0] rd_word;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_word <= 8'd0;
    end else if ({1'b0, rd_addr} < 7'(DEPTH)) begin
      rd_word <= mem[rd_addr];
    end else begin
      rd_word <= TERM_WORD;
    end
  end

  assign {rd_note, rd_dur} = rd_word;

`ifdef REC_LIVE_MONITOR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_to_play <= 4'd0;
      led_out      <= 7'd0;
    end else if (recording) begin
      note_to_play <= acc_code;
      led_out      <= (acc_code == 4'd0) ? 7'd0 : (7'd1 << (acc_code - 4'd1));
    end else begin
      note_to_play <= 4'd0;
      led_out      <= 7'd0;
    end
  end
`else
  assign note_to_play = 4'd0;
  assign led_out      = 7'd0;
`endif

endmodule

// File: tb/tb_song_recorder.sv
// tb/tb_song_recorder.sv - directed scoreboard bench for song_recorder
// Builds with or without REC_LIVE_MONITOR_EN.
module tb_song_recorder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [6:0] key_in;
  logic       rec_start, rec_stop;
  logic [5:0] rd_addr;
  logic [3:0] rd_note, rd_dur, note_to_play;
  logic [5:0] rec_len;
  logic       recording, full;
  logic [6:0] led_out;

  logic [6:0] s_key;
  logic       s_start, s_stop;
  logic [5:0] s_rd_addr;
  logic [3:0] s_rd_note, s_rd_dur, s_note;
  logic [5:0] s_rec_len;
  logic       s_recording, s_full;
  logic [6:0] s_led;

`ifdef REC_LIVE_MONITOR_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  song_recorder #(.DEPTH(56), .TICK_CYCLES(10), .DEBOUNCE_CYCLES(4), .MAX_DUR(15)) u_dut (
    .clk(clk), .reset(reset), .key_in(key_in), .rec_start(rec_start), .rec_stop(rec_stop),
    .rd_addr(rd_addr), .rd_note(rd_note), .rd_dur(rd_dur), .rec_len(rec_len),
    .recording(recording), .full(full), .note_to_play(note_to_play), .led_out(led_out)
  );

  song_recorder #(.DEPTH(4), .TICK_CYCLES(10), .DEBOUNCE_CYCLES(4), .MAX_DUR(15)) u_small (
    .clk(clk), .reset(reset), .key_in(s_key), .rec_start(s_start), .rec_stop(s_stop),
    .rd_addr(s_rd_addr), .rd_note(s_rd_note), .rd_dur(s_rd_dur), .rec_len(s_rec_len),
    .recording(s_recording), .full(s_full), .note_to_play(s_note), .led_out(s_led)
  );

  int total = 0;
  int bad   = 0;
  logic [13:0] sb_q[$];
  logic [13:0] sb_s[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_big(input int a, input logic [7:0] d);
    sb_q.push_back({6'(a), d});
  endtask

  task automatic push_small(input int a, input logic [7:0] d);
    sb_s.push_back({6'(a), d});
  endtask

  task automatic drain_big();
    logic [13:0] e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rd_addr = e[13:8];
      tick(1);
      chk($sformatf("mem[%0d]", e[13:8]), {24'd0, rd_note, rd_dur}, {24'd0, e[7:0]});
    end
  endtask

  task automatic drain_small();
    logic [13:0] e;
    while (sb_s.size() > 0) begin
      e = sb_s.pop_front();
      s_rd_addr = e[13:8];
      tick(1);
      chk($sformatf("small_mem[%0d]", e[13:8]), {24'd0, s_rd_note, s_rd_dur}, {24'd0, e[7:0]});
    end
  endtask

  task automatic start_pulse();
    rec_start = 1'b1;
    tick(1);
    rec_start = 1'b0;
  endtask

  task automatic stop_pulse();
    rec_stop = 1'b1;
    tick(1);
    rec_stop = 1'b0;
  endtask

  initial begin
    // 1: reset with random keys held
    reset = 1'b0;
    key_in = 7'($urandom);
    s_key = 7'($urandom);
    rec_start = 1'b0; rec_stop = 1'b0; rd_addr = 6'd60;
    s_start = 1'b0; s_stop = 1'b0; s_rd_addr = 6'd0;
    tick(3);
    chk("rst_recording", {31'd0, recording}, 32'd0);
    chk("rst_rec_len", {26'd0, rec_len}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_rd_note", {28'd0, rd_note}, 32'd0);
    chk("rst_note_to_play", {28'd0, note_to_play}, 32'd0);
    chk("rst_led_out", {25'd0, led_out}, 32'd0);
    reset = 1'b1;
    tick(1);
    chk("oob_rd_note", {28'd0, rd_note}, 32'hF);
    chk("oob_rd_dur", {28'd0, rd_dur}, 32'd0);
    chk("idle_recording", {31'd0, recording}, 32'd0);
    key_in = 7'd0;
    s_key = 7'd0;
    tick(10);

    // 2: one note, a short rest, then stop
    start_pulse();
    tick(2);
    key_in = 7'b0000100;
    push_big(0, 8'h34);
    tick(20);
    chk("rec_recording", {31'd0, recording}, 32'd1);
    chk("mon_led", {25'd0, led_out}, MON ? 32'h04 : 32'h0);
    chk("mon_note", {28'd0, note_to_play}, MON ? 32'h3 : 32'h0);
    tick(15);
    key_in = 7'd0;
    push_big(1, 8'h01);
    push_big(2, 8'hF0);
    tick(10);
    stop_pulse();
    tick(5);
    chk("t2_recording", {31'd0, recording}, 32'd0);
    chk("t2_rec_len", {26'd0, rec_len}, 32'd2);
    chk("t2_full", {31'd0, full}, 32'd0);
    chk("t2_led_idle", {25'd0, led_out}, 32'd0);
    drain_big();

    // 3: short glitch while armed, then two-key chord and further notes
    start_pulse();
    tick(2);
    key_in = 7'b0000001;
    tick(3);
    key_in = 7'd0;
    tick(12);
    chk("t3_armed_len", {26'd0, rec_len}, 32'd0);
    chk("t3_armed_rec", {31'd0, recording}, 32'd1);
    key_in = 7'b0010010;
    push_big(0, 8'h23);
    tick(25);
    key_in = 7'b0100000;
    push_big(1, 8'h63);
    tick(25);
    key_in = 7'b1000000;
    push_big(2, 8'h73);
    tick(25);
    key_in = 7'd0;
    push_big(3, 8'h01);
    push_big(4, 8'hF0);
    tick(10);
    stop_pulse();
    tick(5);
    chk("t3_rec_len", {26'd0, rec_len}, 32'd4);
    drain_big();

    // 4: long note saturates duration
    start_pulse();
    tick(2);
    key_in = 7'b0001000;
    push_big(0, 8'h4F);
    push_big(1, 8'hF0);
    tick(200);
    stop_pulse();
    tick(5);
    key_in = 7'd0;
    chk("t4_rec_len", {26'd0, rec_len}, 32'd1);
    drain_big();

    // 5: DEPTH=4 fills and auto-stops
    s_start = 1'b1;
    tick(1);
    s_start = 1'b0;
    tick(2);
    push_small(0, 8'h12);
    push_small(1, 8'h22);
    push_small(2, 8'h12);
    push_small(3, 8'hF0);
    for (int i = 0; i < 5; i++) begin
      s_key = (i % 2 == 0) ? 7'b0000001 : 7'b0000010;
      tick(20);
    end
    s_key = 7'd0;
    tick(5);
    chk("t5_full", {31'd0, s_full}, 32'd1);
    chk("t5_recording", {31'd0, s_recording}, 32'd0);
    chk("t5_rec_len", {26'd0, s_rec_len}, 32'd3);
    drain_small();

    // 6: reset mid-take leaves memory as it was, no terminator
    key_in = 7'd0;
    tick(10);
    start_pulse();
    tick(2);
    key_in = 7'b0000001;
    tick(15);
    key_in = 7'b0000010;
    tick(15);
    key_in = 7'b0000100;
    tick(15);
    chk("t6_pre_len", {26'd0, rec_len}, 32'd2);
    chk("t6_pre_rec", {31'd0, recording}, 32'd1);
    reset = 1'b0;
    tick(1);
    chk("t6_recording", {31'd0, recording}, 32'd0);
    chk("t6_rec_len", {26'd0, rec_len}, 32'd0);
    reset = 1'b1;
    key_in = 7'd0;
    tick(3);
    push_big(0, 8'h12);
    push_big(1, 8'h22);
    push_big(2, 8'h73);
    drain_big();

    // 6b: simultaneous start and stop from idle
    tick(10);
    rec_start = 1'b1;
    rec_stop = 1'b1;
    tick(1);
    rec_start = 1'b0;
    rec_stop = 1'b0;
    tick(3);
    chk("t6b_recording", {31'd0, recording}, 32'd0);
    push_big(0, 8'h12);
    drain_big();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
